rx_frame_guard: RTL and testbench
=================================

RX_FRAME_GUARD -- requirements
Module: rx_frame_guard

Interface
REQ-001 Parameter MAX_BEATS, default 190: maximum 64-byte beats per frame (about 12 KB); longer frames are truncated.
REQ-002 clk  input  1  sole clock, the CMAC rx clock domain; all logic is rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 link_reset  input  1  driven from the upstream sys_reset_out; high means the link is being reset.
REQ-005 rx_in_tdata/tkeep/tlast/tuser/tvalid  input  512/64/1/1/1  AXIS from the upstream rx_out; no tready, so every valid beat is accepted.
REQ-006 rx_out_tdata/tkeep/tlast/tuser/tvalid  output  512/64/1/1/1  AXIS to the packet-capture datapath; no tready.
REQ-007 frames_good, frames_bad, frames_aborted  output  32 each  statistics counters, present only when STATS_EN is defined (REQ-021).

Function
REQ-008 The block SHALL guarantee that rx_out carries only whole frames; every frame ends with a tlast beat.
REQ-009 All outputs SHALL be registered; a forwarded beat appears on rx_out exactly 1 cycle after it is accepted on rx_in, with its data unchanged.
REQ-010 The state machine SHALL have four states: SYNC, IDLE, FRAME and DROP.
REQ-011 SYNC: discard every beat. On a valid beat with tlast=1, go to IDLE.
REQ-012 IDLE, valid beat with tlast=0: forward it, load the beat counter with 1, go to FRAME.
REQ-013 IDLE, valid beat with tlast=1: forward it as a single-beat frame and stay in IDLE.
REQ-014 FRAME: forward each valid beat and increment the beat counter. On tlast=1, go to IDLE. Gaps in tvalid mid-frame are permitted and are not errors.
REQ-015 FRAME, valid beat with tlast=0 arriving when the beat counter equals MAX_BEATS-1:
- forward that beat with tlast forced to 1 and tuser forced to 1;
- go to DROP.
REQ-016 DROP: discard every beat. On a valid beat with tlast=1, go to IDLE.
REQ-017 link_reset high in FRAME, whether or not rx_in_tvalid is high that cycle:
- any beat on rx_in that cycle is discarded;
- emit exactly one abort beat on the next cycle: tvalid=1, tlast=1, tuser=1, tkeep=64'h1, tdata=0;
- go to SYNC.
REQ-018 link_reset high in IDLE, DROP or SYNC: go to SYNC with no output beat. Beats are discarded while link_reset stays high.
REQ-019 The forwarded tuser value SHALL pass through unchanged; tuser=1 on a tlast beat marks a bad frame (FCS/error) and the frame is still forwarded.
REQ-020 When no beat is forwarded, rx_out_tvalid=0 and rx_out_tlast=0, rx_out_tuser=0.

Configuration
REQ-021 Macro RX_FRAME_GUARD_STATS_EN:
- Defined: the three counters exist. Each counts at most once per cycle, and counting SHALL saturate at 32'hFFFFFFFF.
- frames_good increments on each forwarded tlast beat with tuser=0.
- frames_bad increments on each forwarded tlast beat whose tuser=1 came from rx_in.
- frames_aborted increments on each truncation (REQ-015) or abort beat (REQ-017).
- Not defined: the counter ports and counter logic are absent; all other behaviour is identical.

Reset
REQ-022 rst asserted SHALL, asynchronously:
- set the state to SYNC and the beat counter to 0;
- drive rx_out_tvalid, tlast and tuser to 0;
- set the counters to 0.
rx_out_tdata/tkeep are don't-care during reset.
REQ-023 rst asserted mid-frame SHALL NOT emit an abort beat. After rst deasserts, the first forwarded frame is the one that follows the first observed tlast.

Verification
REQ-024 After rst, drive 3 beats (tlast on beat 3) followed by a 2-beat frame -> the first frame is discarded; the 2-beat frame appears 1 cycle delayed; frames_good=1.
REQ-025 From IDLE, a 4-beat frame with tvalid gaps of 2 cycles between beats -> all 4 beats are forwarded intact, including tlast.
REQ-026 From IDLE, a 200-beat frame with MAX_BEATS=190 -> 190 beats are output, beat 190 has tlast=1 and tuser=1, the remaining 10 beats are dropped, the next frame passes; frames_aborted=1.
REQ-027 link_reset pulsed on beat 5 of a frame -> one abort beat (tkeep=64'h1, tlast=1, tuser=1); nothing is output until a tlast is seen after link_reset drops.
REQ-028 A 1-beat frame with tuser=1 and tlast=1 in IDLE -> forwarded with tuser=1; frames_bad=1, frames_good unchanged.
REQ-029 Counter preloaded to 32'hFFFFFFFF by force (STATS_EN defined), then another good frame -> frames_good stays at 32'hFFFFFFFF.

Source files
------------

// File: rtl/rx_frame_guard.sv
// Receive-side frame guard: forwards only whole AXIS frames, truncates overlong ones and
// closes frames cut by a link reset. Optional counters are enabled by RX_FRAME_GUARD_STATS_EN.
module rx_frame_guard #(
  parameter int MAX_BEATS = 190
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         link_reset,
  input  logic [511:0] rx_in_tdata,
  input  logic [63:0]  rx_in_tkeep,
  input  logic         rx_in_tlast,
  input  logic         rx_in_tuser,
  input  logic         rx_in_tvalid,
  output logic [511:0] rx_out_tdata,
  output logic [63:0]  rx_out_tkeep,
  output logic         rx_out_tlast,
  output logic         rx_out_tuser,
  output logic         rx_out_tvalid
`ifdef RX_FRAME_GUARD_STATS_EN
  ,
  output logic [31:0]  frames_good,
  output logic [31:0]  frames_bad,
  output logic [31:0]  frames_aborted
`endif
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    FRAME,
    DROP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               user_q, user_d;
  logic [511:0]       data_q, data_d;
  logic [63:0]        keep_q, keep_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC;
      beats_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  // Payload carries no reset: it is only meaningful while valid_q is high.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    keep_q <= keep_d;
  end

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    user_d  = 1'b0;
    data_d  = rx_in_tdata;
    keep_d  = rx_in_tkeep;

    if (link_reset) begin
      state_d = SYNC;
      beats_d = '0;
      // Only an open frame needs closing; the incoming beat is dropped either way.
      if (state_q == FRAME) begin
        valid_d = 1'b1;
        last_d  = 1'b1;
        user_d  = 1'b1;
        data_d  = '0;
        keep_d  = 64'h1;
      end
    end else begin
      case (state_q)
        SYNC, DROP: begin
          if (rx_in_tvalid && rx_in_tlast) begin
            state_d = IDLE;
          end
        end
        IDLE: begin
          if (rx_in_tvalid) begin
            valid_d = 1'b1;
            last_d  = rx_in_tlast;
            user_d  = rx_in_tuser;
            if (!rx_in_tlast) begin
              beats_d = CNT_W'(1);
              state_d = FRAME;
            end
          end
        end
        FRAME: begin
          if (rx_in_tvalid) begin
            valid_d = 1'b1;
            last_d  = rx_in_tlast;
            user_d  = rx_in_tuser;
            if (rx_in_tlast) begin
              beats_d = '0;
              state_d = IDLE;
            end else if (beats_q == CNT_W'(MAX_BEATS - 1)) begin
              // This beat fills the frame: close it as a bad frame and skip the rest.
              last_d  = 1'b1;
              user_d  = 1'b1;
              beats_d = '0;
              state_d = DROP;
            end else begin
              beats_d = beats_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = SYNC;
          beats_d = '0;
        end
      endcase
    end
  end

  assign rx_out_tdata  = data_q;
  assign rx_out_tkeep  = keep_q;
  assign rx_out_tlast  = last_q;
  assign rx_out_tuser  = user_q;
  assign rx_out_tvalid = valid_q;

`ifdef RX_FRAME_GUARD_STATS_EN
  logic        good_inc, bad_inc, abort_inc;
  logic [31:0] frames_good_q, frames_bad_q, frames_aborted_q;

  // A closing beat is upstream's own tlast unless link_reset fired or tlast was forced.
  assign good_inc  = valid_d & last_d & ~user_d;
  assign bad_inc   = valid_d & last_d & user_d & rx_in_tlast & ~link_reset;
  assign abort_inc = valid_d & last_d & (link_reset | ~rx_in_tlast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_good_q    <= '0;
      frames_bad_q     <= '0;
      frames_aborted_q <= '0;
    end else begin
      if (good_inc && frames_good_q != 32'hFFFF_FFFF) begin
        frames_good_q <= frames_good_q + 32'd1;
      end
      if (bad_inc && frames_bad_q != 32'hFFFF_FFFF) begin
        frames_bad_q <= frames_bad_q + 32'd1;
      end
      if (abort_inc && frames_aborted_q != 32'hFFFF_FFFF) begin
        frames_aborted_q <= frames_aborted_q + 32'd1;
      end
    end
  end

  assign frames_good    = frames_good_q;
  assign frames_bad     = frames_bad_q;
  assign frames_aborted = frames_aborted_q;
`endif

endmodule

// File: tb/tb_rx_frame_guard.sv
// Bench for rx_frame_guard: vector table, directed truncation/reset sequences and a
// randomized run against a frame-level reference model.
module tb_rx_frame_guard;
  localparam int MAXB = 190;

  logic         clk = 1'b0;
  logic         rst;
  logic         link_reset;
  logic [511:0] rx_in_tdata;
  logic [63:0]  rx_in_tkeep;
  logic         rx_in_tlast, rx_in_tuser, rx_in_tvalid;
  logic [511:0] rx_out_tdata;
  logic [63:0]  rx_out_tkeep;
  logic         rx_out_tlast, rx_out_tuser, rx_out_tvalid;
`ifdef RX_FRAME_GUARD_STATS_EN
  logic [31:0]  frames_good, frames_bad, frames_aborted;
`endif

  always #5 clk = ~clk;

  rx_frame_guard #(.MAX_BEATS(MAXB)) dut (
    .clk           (clk),
    .rst           (rst),
    .link_reset    (link_reset),
    .rx_in_tdata   (rx_in_tdata),
    .rx_in_tkeep   (rx_in_tkeep),
    .rx_in_tlast   (rx_in_tlast),
    .rx_in_tuser   (rx_in_tuser),
    .rx_in_tvalid  (rx_in_tvalid),
    .rx_out_tdata  (rx_out_tdata),
    .rx_out_tkeep  (rx_out_tkeep),
    .rx_out_tlast  (rx_out_tlast),
    .rx_out_tuser  (rx_out_tuser),
    .rx_out_tvalid (rx_out_tvalid)
`ifdef RX_FRAME_GUARD_STATS_EN
    ,
    .frames_good   (frames_good),
    .frames_bad    (frames_bad),
    .frames_aborted(frames_aborted)
`endif
  );

  typedef struct {
    bit lr, v, l, u;
    bit ev, el, eu;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Reference model: "skipping" means waiting for the next tlast; open_len counts the
  // beats already forwarded for the frame in progress (0 between frames).
  bit m_skip;
  int m_open;
  int m_good, m_bad, m_abort;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
  endtask

  task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_skip  = 1'b1;
    m_open  = 0;
    m_good  = 0;
    m_bad   = 0;
    m_abort = 0;
  endtask

  // Applies one cycle of input, advances the model, and checks the resulting output beat.
  task automatic drive(input string tag, input bit lr, input bit v, input bit l, input bit u,
                       output bit ev, output bit el, output bit eu);
    logic [511:0] d;
    logic [63:0]  k;
    logic [511:0] ed;
    logic [63:0]  ek;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
    k = {$urandom(), $urandom()};
    link_reset   = lr;
    rx_in_tvalid = v;
    rx_in_tlast  = l;
    rx_in_tuser  = u;
    rx_in_tdata  = d;
    rx_in_tkeep  = k;
    ev = 1'b0; el = 1'b0; eu = 1'b0; ed = d; ek = k;
    if (lr) begin
      if (!m_skip && m_open > 0) begin
        ev = 1'b1; el = 1'b1; eu = 1'b1; ed = '0; ek = 64'h1;
        m_abort++;
      end
      m_skip = 1'b1;
      m_open = 0;
    end else if (v) begin
      if (m_skip) begin
        if (l) m_skip = 1'b0;
      end else begin
        m_open++;
        ev = 1'b1; el = l; eu = u;
        if (l) begin
          m_open = 0;
          if (u) m_bad++;
          else m_good++;
        end else if (m_open == MAXB) begin
          el = 1'b1; eu = 1'b1;
          m_skip = 1'b1;
          m_open = 0;
          m_abort++;
        end
      end
    end
    @(posedge clk);
    #1;
    chk_b({tag, ".valid"}, rx_out_tvalid, ev);
    chk_b({tag, ".last"}, rx_out_tlast, el);
    chk_b({tag, ".user"}, rx_out_tuser, eu);
    if (ev) begin
      chk_w({tag, ".data"}, rx_out_tdata, ed);
      chk_w({tag, ".keep"}, 512'(rx_out_tkeep), 512'(ek));
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef RX_FRAME_GUARD_STATS_EN
    chk_w({tag, ".good"}, 512'(frames_good), 512'(m_good));
    chk_w({tag, ".bad"}, 512'(frames_bad), 512'(m_bad));
    chk_w({tag, ".aborted"}, 512'(frames_aborted), 512'(m_abort));
`else
    $display("stats %s: counters not built", tag);
`endif
  endtask

  // Sends an n-beat frame from IDLE and checks truncation explicitly.
  task automatic long_frame(input int n);
    bit ev, el, eu;
    int fwd_len;
    int outs;
    fwd_len = (n < MAXB) ? n : MAXB;
    outs = 0;
    for (int i = 0; i < n; i++) begin
      drive($sformatf("frame%0d.b%0d", n, i), 1'b0, 1'b1, (i == n - 1), 1'b0, ev, el, eu);
      chk_b($sformatf("frame%0d.b%0d.fwd", n, i), rx_out_tvalid, (i < fwd_len));
      chk_b($sformatf("frame%0d.b%0d.tlast", n, i), rx_out_tlast, (i == fwd_len - 1));
      chk_b($sformatf("frame%0d.b%0d.tuser", n, i), rx_out_tuser, (n > MAXB && i == MAXB - 1));
      if (rx_out_tvalid === 1'b1) outs++;
    end
    link_reset = 1'b0;
    rx_in_tvalid = 1'b0;
    $display("frame len=%0d beats_out=%0d", n, outs);
  endtask

  vec_t tbl[31];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit ev, el, eu;
    int target, sent;
    bit lr, v, l, u;

    tbl = '{
      '{0,1,0,0, 0,0,0}, '{0,1,0,0, 0,0,0}, '{0,1,1,0, 0,0,0},   // frame seen in sync: dropped
      '{0,1,0,0, 1,0,0}, '{0,1,1,0, 1,1,0},                       // 2-beat frame passes
      '{0,1,1,1, 1,1,1},                                          // single-beat bad frame
      '{0,1,0,0, 1,0,0}, '{0,0,0,0, 0,0,0}, '{0,0,0,0, 0,0,0},   // gapped 4-beat frame
      '{0,1,0,1, 1,0,1}, '{0,0,0,0, 0,0,0}, '{0,0,0,0, 0,0,0},
      '{0,1,0,0, 1,0,0}, '{0,0,0,0, 0,0,0}, '{0,0,0,0, 0,0,0},
      '{0,1,1,0, 1,1,0},
      '{0,1,0,0, 1,0,0}, '{0,1,0,0, 1,0,0}, '{0,1,0,0, 1,0,0}, '{0,1,0,0, 1,0,0},
      '{1,1,0,0, 1,1,1},                                          // link reset on beat 5
      '{1,1,1,0, 0,0,0}, '{0,1,0,0, 0,0,0}, '{0,1,1,0, 0,0,0},   // resync
      '{0,1,1,0, 1,1,0},
      '{1,0,0,0, 0,0,0}, '{0,1,1,0, 0,0,0},                       // link reset in idle
      '{0,1,0,0, 1,0,0}, '{1,0,0,0, 1,1,1},                       // link reset, no tvalid
      '{0,1,1,0, 0,0,0}, '{0,1,1,1, 1,1,1}
    };

    rst = 1'b1;
    link_reset = 1'b0;
    rx_in_tvalid = 1'b0;
    rx_in_tlast = 1'b0;
    rx_in_tuser = 1'b0;
    rx_in_tdata = '0;
    rx_in_tkeep = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_b("reset.valid", rx_out_tvalid, 1'b0);
    chk_b("reset.last", rx_out_tlast, 1'b0);
    chk_b("reset.user", rx_out_tuser, 1'b0);
    check_stats("reset");
    rst = 1'b0;

    for (int i = 0; i < 31; i++) begin
      drive($sformatf("vec%0d", i), tbl[i].lr, tbl[i].v, tbl[i].l, tbl[i].u, ev, el, eu);
      chk_b($sformatf("vec%0d.tbl_valid", i), rx_out_tvalid, tbl[i].ev);
      chk_b($sformatf("vec%0d.tbl_last", i), rx_out_tlast, tbl[i].el);
      chk_b($sformatf("vec%0d.tbl_user", i), rx_out_tuser, tbl[i].eu);
`ifdef RX_FRAME_GUARD_STATS_EN
      if (i == 4) chk_w("vec4.frames_good", 512'(frames_good), 512'd1);
`endif
      $display("vec %0d lr=%0b v=%0b l=%0b u=%0b -> v=%0b l=%0b u=%0b", i, tbl[i].lr,
               tbl[i].v, tbl[i].l, tbl[i].u, rx_out_tvalid, rx_out_tlast, rx_out_tuser);
    end
`ifdef RX_FRAME_GUARD_STATS_EN
    chk_w("table.good", 512'(frames_good), 512'd3);
    chk_w("table.bad", 512'(frames_bad), 512'd2);
    chk_w("table.aborted", 512'(frames_aborted), 512'd2);
`endif

    long_frame(200);
    long_frame(1);
    long_frame(MAXB);
    long_frame(MAXB + 1);
    long_frame(2);
    check_stats("long");

    // Reset mid-frame: outputs clear immediately and no abort beat follows.
    drive("rstmid.b0", 1'b0, 1'b1, 1'b0, 1'b0, ev, el, eu);
    drive("rstmid.b1", 1'b0, 1'b1, 1'b0, 1'b0, ev, el, eu);
    rst = 1'b1;
    #2;
    chk_b("rstmid.async_valid", rx_out_tvalid, 1'b0);
    model_reset();
    check_stats("rstmid");
    @(posedge clk);
    #1;
    chk_b("rstmid.no_abort", rx_out_tvalid, 1'b0);
    rst = 1'b0;
    drive("rstmid.c0", 1'b0, 1'b1, 1'b0, 1'b0, ev, el, eu);
    drive("rstmid.c1", 1'b0, 1'b1, 1'b1, 1'b0, ev, el, eu);
    drive("rstmid.c2", 1'b0, 1'b1, 1'b1, 1'b0, ev, el, eu);
    chk_b("rstmid.first_after", rx_out_tvalid, 1'b1);
    $display("reset mid-frame sequence done");

    target = 0;
    sent = 0;
    for (int c = 0; c < 3000; c++) begin
      if (target == 0) target = ($urandom_range(0, 9) == 0) ? $urandom_range(180, 210)
                                                           : $urandom_range(1, 6);
      lr = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 9) < 7);
      l  = v && (sent + 1 == target);
      u  = ($urandom_range(0, 3) == 0);
      drive($sformatf("rand%0d", c), lr, v, l, u, ev, el, eu);
      if (v && !lr) begin
        sent++;
        if (l) begin
          sent = 0;
          target = 0;
        end
      end
    end
    check_stats("random");
    $display("random run done: good=%0d bad=%0d aborted=%0d", m_good, m_bad, m_abort);

`ifdef RX_FRAME_GUARD_STATS_EN
    drive("sat.lr", 1'b1, 1'b0, 1'b0, 1'b0, ev, el, eu);
    drive("sat.sync", 1'b0, 1'b1, 1'b1, 1'b0, ev, el, eu);
    link_reset = 1'b0;
    rx_in_tvalid = 1'b0;
    force dut.frames_good_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.frames_good_q;
    drive("sat.good", 1'b0, 1'b1, 1'b1, 1'b0, ev, el, eu);
    chk_w("sat.frames_good", 512'(frames_good), 512'(32'hFFFF_FFFF));
    drive("sat.bad", 1'b0, 1'b1, 1'b1, 1'b1, ev, el, eu);
    chk_w("sat.frames_bad", 512'(frames_bad), 512'(m_bad));
    chk_w("sat.frames_good_hold", 512'(frames_good), 512'(32'hFFFF_FFFF));
    $display("saturation sequence done");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
